// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq -- ALU control decoder with a valid/ready beat sequencer.
//
// A request (aluop, funct, shamt) is accepted on in_valid && in_ready. It is
// decoded into a GW-bit ALU control code (5-bit code zero-extended) and issued
// as one or more output beats. A shift-right request issues max(shamt,1)
// beats, one 1-bit shift step per beat. Every other op issues a single beat.
// An illegal request issues a single add beat with err set.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake
//   aluop[1:0]          {aluop1, aluop0} from main control
//   funct[FW-1:0]       instruction function field
//   shamt[SHW-1:0]      shift amount
//   out_valid/out_ready beat handshake
//   gout[GW-1:0]        ALU control code of the current beat
//   out_last            final beat of the current request
//   err                 current request decoded as illegal
module alu_ctrl_seq #(
    parameter int GW  = 5,
    parameter int FW  = 4,
    parameter int SHW = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [1:0]     aluop,
    input  logic [FW-1:0]  funct,
    input  logic [SHW-1:0] shamt,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [GW-1:0]  gout,
    output logic           out_last,
    output logic           err
);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t         state, state_nxt;

    logic [1:0]     aluop_q;
    logic [FW-1:0]  funct_q;
    logic [SHW-1:0] shamt_q;
    logic [SHW-1:0] cnt;
    logic [SHW-1:0] cnt_load;
    logic [5:0]     dec_q;
    logic           accept;
    logic           consume;
    logic           is_shift_in;

    // Returns {illegal, code[4:0]}. Illegal requests carry the add code.
    function automatic logic [5:0] decode(input logic [1:0] op, input logic [FW-1:0] f);
        logic [4:0] code;
        logic       ill;
        logic       hi;
        hi   = |(f >> 4);
        ill  = 1'b0;
        code = 5'b00010;
        case (op)
            2'b00: code = 5'b00010;
            2'b01: code = 5'b01010;
            2'b11: code = 5'b11000;
            default: begin
                if (f[1] && f[2])       code = 5'b00100;
                else if (f[2] && f[0])  code = 5'b00001;
                else if (f[2] && !f[0]) code = 5'b00000;
                else if (f[1] && f[3])  code = 5'b01011;
                else if (f[1] && !f[3]) code = 5'b01010;
                else if (f[3:0] == 4'b0000) code = 5'b00010;
                else ill = 1'b1;
            end
        endcase
        if (hi) ill = 1'b1;
        if (ill) code = 5'b00010;
        return {ill, code};
    endfunction

    // Outputs are decoded from the captured request; they are only driven
    // while a beat is present, which also gives zero after reset.
    assign dec_q     = decode(aluop_q, funct_q);
    assign out_valid = (state == EMIT);
    assign out_last  = (state == EMIT) && (cnt == '0);
    assign gout      = (state == EMIT) ? GW'(dec_q[4:0]) : '0;
    assign err       = (state == EMIT) && dec_q[5];

    assign consume   = out_valid && out_ready;
    assign in_ready  = (state == IDLE) || (consume && out_last);
    assign accept    = in_valid && in_ready;

    // Only a legal shift-right needs more than one beat.
    assign is_shift_in = (aluop == 2'b10) && funct[1] && funct[2] && !(|(funct >> 4));
    assign cnt_load    = (!is_shift_in || shamt == '0) ? '0 : shamt - SHW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = EMIT;
            end
            EMIT: begin
                // Back-to-back acceptance on the final beat stays in EMIT.
                if (consume && out_last) state_nxt = accept ? EMIT : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aluop_q <= '0;
            funct_q <= '0;
            shamt_q <= '0;
            cnt     <= '0;
        end else begin
            assert (cnt <= shamt_q);
            if (accept) begin
                aluop_q <= aluop;
                funct_q <= funct;
                shamt_q <= shamt;
                cnt     <= cnt_load;
            end else if (consume && !out_last) begin
                cnt <= cnt - SHW'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
module tb_alu_ctrl_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] aluop = 2'b00;
    logic [3:0] funct = 4'b0000;
    logic [4:0] shamt = 5'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [4:0] gout;
    logic       out_last;
    logic       err;

    alu_ctrl_seq #(.GW(5), .FW(4), .SHW(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluop     (aluop),
        .funct     (funct),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .gout      (gout),
        .out_last  (out_last),
        .err       (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference table for aluop=10, indexed by funct: {illegal, code}.
    function automatic logic [5:0] ref_row(input logic [3:0] f);
        case (f)
            4'd0:                       return 6'b0_00010;
            4'd2, 4'd3:                 return 6'b0_01010;
            4'd4, 4'd12:                return 6'b0_00000;
            4'd5, 4'd13:                return 6'b0_00001;
            4'd6, 4'd7, 4'd14, 4'd15:   return 6'b0_00100;
            4'd10, 4'd11:               return 6'b0_01011;
            default:                    return 6'b1_00010;
        endcase
    endfunction

    function automatic logic [5:0] ref_req(input logic [1:0] op, input logic [3:0] f);
        case (op)
            2'b00:   return 6'b0_00010;
            2'b01:   return 6'b0_01010;
            2'b11:   return 6'b0_11000;
            default: return ref_row(f);
        endcase
    endfunction

    typedef struct packed {
        logic [4:0] g;
        logic       last;
        logic       e;
    } beat_t;

    beat_t q[$];
    bit    fresh = 1'b1;

    // Model: queue of expected beats; checked every cycle at the falling edge.
    always @(negedge clk) begin
        logic       exp_v;
        logic       exp_rdy;
        logic [5:0] r;
        int         n;
        if (!rst_n) begin
            q.delete();
            fresh = 1'b1;
            chk("rst_valid", out_valid, 0);
            chk("rst_gout", gout, 0);
            chk("rst_err", err, 0);
            chk("rst_last", out_last, 0);
        end else begin
            exp_v = (q.size() != 0);
            chk("valid", out_valid, exp_v);
            exp_rdy = 1'b1;
            if (exp_v) begin
                chk("gout", gout, q[0].g);
                chk("last", out_last, q[0].last);
                chk("err", err, q[0].e);
                exp_rdy = out_ready && q[0].last;
            end else if (fresh) begin
                chk("fresh_gout", gout, 0);
                chk("fresh_err", err, 0);
                chk("fresh_last", out_last, 0);
            end
            chk("in_ready", in_ready, exp_rdy);
            if (exp_v && out_ready) void'(q.pop_front());
            if (in_valid && exp_rdy) begin
                fresh = 1'b0;
                r = ref_req(aluop, funct);
                n = (!r[5] && r[4:0] == 5'b00100) ? ((shamt == 0) ? 1 : int'(shamt)) : 1;
                for (int i = 0; i < n; i++) q.push_back('{r[4:0], (i == n - 1), r[5]});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [1:0] op, input logic [3:0] f, input logic [4:0] sh);
        logic acc;
        int   n;
        aluop    = op;
        funct    = f;
        shamt    = sh;
        in_valid = 1'b1;
        n        = 0;
        acc      = 1'b0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            step();
            n++;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no acceptance want acceptance at %0t", $time);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 400) begin
            step();
            n++;
        end
        if (n >= 400) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got busy want idle at %0t", $time);
        end
        step();
    endtask

    bit done = 1'b0;

    initial begin
        #1;
        chk("lit_rst_valid", out_valid, 0);
        chk("lit_rst_gout", gout, 0);
        chk("lit_rst_ready", in_ready, 1);
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // and, single beat
        send(2'b10, 4'b0100, 5'd0);
        chk("lit_and_gout", gout, 5'b00000);
        chk("lit_and_last", out_last, 1);
        chk("lit_and_err", err, 0);
        step();
        chk("lit_and_idle", out_valid, 0);

        // shift of 3 beats, then shamt=0
        send(2'b10, 4'b0110, 5'd3);
        chk("lit_sh3_g1", gout, 5'b00100);
        chk("lit_sh3_l1", out_last, 0);
        step();
        chk("lit_sh3_l2", out_last, 0);
        step();
        chk("lit_sh3_l3", out_last, 1);
        step();
        chk("lit_sh3_idle", out_valid, 0);
        send(2'b10, 4'b0110, 5'd0);
        chk("lit_sh0_last", out_last, 1);
        step();
        chk("lit_sh0_idle", out_valid, 0);

        // shift of 2 beats under back-pressure
        out_ready = 1'b0;
        send(2'b10, 4'b0110, 5'd2);
        for (int i = 0; i < 4; i++) begin
            chk("lit_stall_valid", out_valid, 1);
            chk("lit_stall_last", out_last, 0);
            chk("lit_stall_gout", gout, 5'b00100);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("lit_stall_b2last", out_last, 1);
        step();
        chk("lit_stall_idle", out_valid, 0);

        // back-to-back: add, nor, illegal
        send(2'b00, 4'b0000, 5'd0);
        chk("lit_add_gout", gout, 5'b00010);
        send(2'b11, 4'b0101, 5'd0);
        chk("lit_nor_valid", out_valid, 1);
        chk("lit_nor_gout", gout, 5'b11000);
        send(2'b10, 4'b1001, 5'd0);
        chk("lit_ill_gout", gout, 5'b00010);
        chk("lit_ill_err", err, 1);
        chk("lit_ill_last", out_last, 1);
        step();
        chk("lit_ill_idle", out_valid, 0);

        // reset during beat 2 of a 5-beat shift
        send(2'b10, 4'b0111, 5'd5);
        step();
        chk("lit_rs_b2", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("lit_rs_valid", out_valid, 0);
        repeat (2) step();
        rst_n = 1'b1;
        #1;
        chk("lit_rs_ready", in_ready, 1);
        chk("lit_rs_gout", gout, 0);
        step();

        // random legal stream with random back-pressure
        fork
            begin
                for (int k = 0; k < 120; k++) begin
                    logic [1:0] op;
                    logic [3:0] f;
                    repeat ($urandom_range(0, 2)) step();
                    op = 2'($urandom_range(0, 3));
                    f  = 4'($urandom_range(0, 15));
                    while (op == 2'b10 && ref_row(f) >= 6'b1_00000) f = 4'($urandom_range(0, 15));
                    send(op, f, 5'($urandom_range(0, 6)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    step();
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
